// File: rtl/as_pack.sv
// Shared types for the as_ immediate generator: selector encoding and the
// buffered result entry used by the output/skid registers.
package as_pack;

   localparam int unsigned IMMSRC_W  = 3;
   localparam int unsigned IMM_MAX_W = 64;

   typedef enum logic [IMMSRC_W-1:0] {
      IMM_I   = 3'd0,
      IMM_S   = 3'd1,
      IMM_B   = 3'd2,
      IMM_J   = 3'd3,
      IMM_U   = 3'd4,
      IMM_Z   = 3'd5,
      IMM_SH  = 3'd6,
      IMM_RSV = 3'd7
   } immsel_e;

   // Sized for the widest datapath; narrower instances ignore the upper bits.
   typedef struct packed {
      logic                 valid;
      logic [IMM_MAX_W-1:0] imm;
      logic [IMM_MAX_W-1:0] target;
      logic                 illegal;
   } imm_entry_t;

endpackage

// File: rtl/as_immgen_core.sv
// Combinational immediate decode for all selector formats, sign- or
// zero-extended to XLEN, with illegal flag for reserved/bad encodings.
module as_immgen_core
   import as_pack::*;
#(
   parameter int unsigned XLEN = 64
) (
   input  logic [24:0]         instr,
   input  logic [IMMSRC_W-1:0] sel,
   output logic [XLEN-1:0]     imm,
   output logic                illegal
);

   logic [31:7]        ins;
   logic signed [31:0] raw;

   assign ins = instr;

   // raw is a 32-bit signed value; zero-extended formats keep bit 31 clear,
   // so one signed resize covers every format.
   always_comb begin
      raw     = '0;
      illegal = 1'b0;
      unique case (immsel_e'(sel))
         IMM_I:   raw = {{20{ins[31]}}, ins[31:20]};
         IMM_S:   raw = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         IMM_B:   raw = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         IMM_J:   raw = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         IMM_U:   raw = {ins[31:12], 12'b0};
         IMM_Z:   raw = {27'b0, ins[19:15]};
         IMM_SH: begin
            if (XLEN == 64) begin
               raw = {26'b0, ins[25:20]};
            end else begin
               raw     = {27'b0, ins[24:20]};
               illegal = ins[25];
            end
         end
         IMM_RSV: begin
            raw     = '0;
            illegal = 1'b1;
         end
         default: begin
            raw     = '0;
            illegal = 1'b1;
         end
      endcase
   end

   assign imm = XLEN'(raw);

endmodule

// File: rtl/as_immgen_pipe.sv
// Registered immediate generator with PC-relative target and a 2-entry
// (output + skid) valid/ready buffer so decode can be back-pressured.
module as_immgen_pipe
   import as_pack::*;
#(
   parameter int unsigned XLEN     = 64,
   parameter int unsigned IMMSRC_W = 3
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                flush_i,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic [24:0]         instr_i,
   input  logic [IMMSRC_W-1:0] sel_i,
   input  logic [XLEN-1:0]     pc_i,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [XLEN-1:0]     imm_o,
   output logic [XLEN-1:0]     target_o,
   output logic                illegal_o
);

   logic [XLEN-1:0] imm_c;
   logic [XLEN-1:0] target_c;
   logic            illegal_c;
   imm_entry_t      in_e;
   imm_entry_t      m_q;
   imm_entry_t      s_q;
   logic            accept;
   logic            xfer;

   as_immgen_core #(.XLEN(XLEN)) u_core (
      .instr   (instr_i),
      .sel     (sel_i),
      .imm     (imm_c),
      .illegal (illegal_c)
   );

   assign target_c = pc_i + imm_c;

   always_comb begin
      in_e         = '0;
      in_e.valid   = 1'b1;
      in_e.imm     = IMM_MAX_W'(imm_c);
      in_e.target  = IMM_MAX_W'(target_c);
      in_e.illegal = illegal_c;
   end

   // Readiness depends only on the skid register, never on out_ready_i.
   assign accept = in_valid_i & ~s_q.valid;
   assign xfer   = m_q.valid & out_ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         m_q <= '0;
         s_q <= '0;
      end else if (flush_i) begin
         m_q.valid <= 1'b0;
         s_q.valid <= 1'b0;
      end else if (!m_q.valid || xfer) begin
         if (s_q.valid) begin
            m_q <= s_q;
            s_q <= accept ? in_e : '0;
         end else begin
            m_q <= accept ? in_e : '0;
         end
      end else if (accept) begin
         s_q <= in_e;
      end
   end

   assign in_ready_o  = ~s_q.valid;
   assign out_valid_o = m_q.valid;
   assign imm_o       = m_q.imm[XLEN-1:0];
   assign target_o    = m_q.target[XLEN-1:0];
   assign illegal_o   = m_q.illegal;

   if (XLEN < IMM_MAX_W) begin : g_narrow
      logic unused_hi;
      assign unused_hi = ^{m_q.imm[IMM_MAX_W-1:XLEN], m_q.target[IMM_MAX_W-1:XLEN]};
   end

endmodule

// File: tb/tb_as_immgen_pipe.sv
// Bench for as_immgen_pipe: XLEN=64 and XLEN=32 instances driven in lockstep,
// compared every cycle against a FIFO-level model plus literal expectations.
module tb_as_immgen_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] instr = '0;
   logic [2:0]  sel = '0;
   logic [63:0] pc = '0;

   logic        rdy64, vld64, ill64, rdy32, vld32, ill32;
   logic [63:0] imm64, tgt64;
   logic [31:0] imm32, tgt32, pc32;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [63:0] imm64;
      logic [63:0] tgt64;
      logic        ill64;
      logic [31:0] imm32;
      logic [31:0] tgt32;
      logic        ill32;
   } exp_t;

   exp_t        q[$];
   logic [63:0] got[$];
   bit          rec = 1'b0;

   logic [31:0] tab [8] = '{32'hFFF00093, 32'hFE000EE3, 32'h800000B7, 32'h7FF0A0EF,
                            32'h02500013, 32'h12345678, 32'hFFFFFFFF, 32'h00000000};
   logic [63:0] pcs [4] = '{64'h0000_0000_0000_1000, 64'hFFFF_FFFF_FFFF_FFF0,
                            64'h0000_0000_8000_0000, 64'h1234_5678_9ABC_DEF0};

   always #5 clk = ~clk;

   assign pc32 = pc[31:0];

   as_immgen_pipe #(.XLEN(64), .IMMSRC_W(3)) dut64 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
      .in_valid_i(in_valid), .in_ready_o(rdy64),
      .instr_i(instr[31:7]), .sel_i(sel), .pc_i(pc),
      .out_valid_o(vld64), .out_ready_i(out_ready),
      .imm_o(imm64), .target_o(tgt64), .illegal_o(ill64)
   );

   as_immgen_pipe #(.XLEN(32), .IMMSRC_W(3)) dut32 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
      .in_valid_i(in_valid), .in_ready_o(rdy32),
      .instr_i(instr[31:7]), .sel_i(sel), .pc_i(pc32),
      .out_valid_o(vld32), .out_ready_i(out_ready),
      .imm_o(imm32), .target_o(tgt32), .illegal_o(ill32)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Immediate value as a signed offset, then reduced to the datapath width.
   function automatic void ref_imm(input logic [31:0] ins, input logic [2:0] s, input bit x64,
                                   output logic [63:0] imm, output logic ill);
      longint v;
      v   = 0;
      ill = 1'b0;
      case (s)
         3'd0: begin v = ins[31:20]; if (ins[31]) v -= 4096; end
         3'd1: begin v = {ins[31:25], ins[11:7]}; if (ins[31]) v -= 4096; end
         3'd2: begin v = {ins[31], ins[7], ins[30:25], ins[11:8]} * 2; if (ins[31]) v -= 8192; end
         3'd3: begin v = {ins[31], ins[19:12], ins[20], ins[30:21]} * 2; if (ins[31]) v -= 2097152; end
         3'd4: begin v = ins[31:12] * 4096; if (ins[31]) v -= 64'h1_0000_0000; end
         3'd5: v = ins[19:15];
         3'd6: begin
            if (x64) v = ins[25:20];
            else begin v = ins[24:20]; ill = ins[25]; end
         end
         default: begin v = 0; ill = 1'b1; end
      endcase
      imm = v;
      if (!x64) imm[63:32] = '0;
   endfunction

   function automatic exp_t mk(input logic [31:0] ins, input logic [2:0] s, input logic [63:0] p);
      exp_t        e;
      logic [63:0] i32;
      ref_imm(ins, s, 1'b1, e.imm64, e.ill64);
      e.tgt64 = p + e.imm64;
      ref_imm(ins, s, 1'b0, i32, e.ill32);
      e.imm32 = i32[31:0];
      e.tgt32 = p[31:0] + i32[31:0];
      return e;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
      end else begin
         bit acc, xf;
         acc = in_valid && (q.size() < 2);
         xf  = (q.size() > 0) && out_ready;
         if (flush) q.delete();
         else begin
            if (xf) void'(q.pop_front());
            if (acc) q.push_back(mk(instr, sel, pc));
         end
      end
   end

   always @(negedge clk) begin
      chk("in_ready64", rdy64, q.size() < 2);
      chk("out_valid64", vld64, q.size() > 0);
      chk("in_ready32", rdy32, q.size() < 2);
      chk("out_valid32", vld32, q.size() > 0);
      if (q.size() > 0 && vld64) begin
         chk("imm64", imm64, q[0].imm64);
         chk("target64", tgt64, q[0].tgt64);
         chk("illegal64", ill64, q[0].ill64);
      end
      if (q.size() > 0 && vld32) begin
         chk("imm32", imm32, q[0].imm32);
         chk("target32", tgt32, q[0].tgt32);
         chk("illegal32", ill32, q[0].ill32);
      end
      if (rec && vld64 && out_ready) got.push_back(imm64);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send1(input logic [31:0] i, input logic [2:0] s, input logic [63:0] p);
      instr    = i;
      sel      = s;
      pc       = p;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      repeat (2) step();
      chk("rst_valid", vld64, 0);
      chk("rst_ready", rdy64, 1);
      chk("rst_imm", imm64, 0);
      chk("rst_target", tgt64, 0);
      chk("rst_illegal", ill64, 0);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      step();

      send1(32'hFFF00093, 3'd0, 64'h1000);
      chk("I_valid", vld64, 1);
      chk("I_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("I_tgt64", tgt64, 64'hFFF);
      chk("I_ill64", ill64, 0);
      chk("I_imm32", imm32, 32'hFFFF_FFFF);
      chk("I_tgt32", tgt32, 32'hFFF);

      send1(32'hFE000EE3, 3'd2, 64'h8000_0000);
      chk("B_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("B_tgt64", tgt64, 64'h7FFF_FFFC);
      chk("B_imm32", imm32, 32'hFFFF_FFFC);
      chk("B_tgt32", tgt32, 32'h7FFF_FFFC);

      send1(32'h800000B7, 3'd4, 64'h0);
      chk("U_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
      chk("U_imm32", imm32, 32'h8000_0000);

      send1(32'h0040006F, 3'd3, 64'h100);
      chk("J_imm64", imm64, 64'h4);
      chk("J_tgt64", tgt64, 64'h104);

      send1(32'h000F8073, 3'd5, 64'h0);
      chk("Z_imm64", imm64, 64'h1F);

      send1(32'h12345678, 3'd7, 64'h40);
      chk("RSV_imm64", imm64, 64'h0);
      chk("RSV_ill64", ill64, 1);
      chk("RSV_tgt64", tgt64, 64'h40);

      send1(32'h02500013, 3'd6, 64'h0);
      chk("SH_imm64", imm64, 64'h25);
      chk("SH_ill64", ill64, 0);
      chk("SH_imm32", imm32, 32'h5);
      chk("SH_ill32", ill32, 1);
      repeat (2) step();

      // Four-entry stream with output stalled for three cycles.
      got.delete();
      rec = 1'b1;
      begin
         int idx = 0;
         for (int cyc = 1; cyc <= 16; cyc++) begin
            bit r;
            in_valid  = (idx < 4);
            instr     = ((idx + 1) << 20) | 32'h13;
            sel       = 3'd0;
            pc        = 64'h0;
            out_ready = (cyc > 3);
            r         = rdy64;
            step();
            if (in_valid && r) begin
               idx++;
               if (idx == 2) chk("ready_low_after_2nd", rdy64, 0);
            end
         end
      end
      in_valid = 1'b0;
      rec      = 1'b0;
      chk("stream_count", got.size(), 4);
      for (int k = 0; k < 4; k++)
         chk($sformatf("stream_%0d", k), (k < got.size()) ? got[k] : 64'hDEAD, k + 1);

      // Flush with both registers full and an input offered.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      instr     = (32'h11 << 20) | 32'h13;
      step();
      instr = (32'h22 << 20) | 32'h13;
      step();
      chk("full_ready", rdy64, 0);
      flush = 1'b1;
      instr = (32'h77 << 20) | 32'h13;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_valid64", vld64, 0);
      chk("flush_ready64", rdy64, 1);
      chk("flush_valid32", vld32, 0);
      out_ready = 1'b1;
      repeat (3) step();
      chk("flush_no_replay", vld64, 0);

      // Asynchronous reset in the middle of a stream.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      pc        = 64'h500;
      instr     = (32'h33 << 20) | 32'h13;
      step();
      instr = (32'h44 << 20) | 32'h13;
      step();
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_valid", vld64, 0);
      chk("mrst_imm", imm64, 0);
      chk("mrst_target", tgt64, 0);
      chk("mrst_illegal", ill64, 0);
      chk("mrst_ready", rdy64, 1);
      chk("mrst_imm32", imm32, 0);
      step();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      repeat (3) step();
      chk("mrst_no_replay", vld64, 0);

      // Every selector against a spread of encodings and PCs, with stalls.
      for (int i = 0; i < 8; i++) begin
         for (int s = 0; s < 8; s++) begin
            int n;
            bit done;
            instr     = tab[i];
            sel       = 3'(s);
            pc        = pcs[(i + s) % 4];
            in_valid  = 1'b1;
            out_ready = ((i * 8 + s) % 3) != 0;
            n         = 0;
            done      = 1'b0;
            while (!done && n < 10) begin
               bit r;
               r = rdy64;
               step();
               if (r) done = 1'b1;
               n++;
               out_ready = 1'b1;
            end
            if (!done) chk("accept_timeout", 0, 1);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
